// File: rtl/hazard_forwarding_unit_if.sv
// ============================================================================
// Module  : hazard_forwarding_unit_if
// Brief   : Pipeline-status and hazard-control bundle for the hazard unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_forwarding_unit_if #(
    parameter int REG_ADD_WIDTH = 5,
    parameter int FW_BUS_WIDTH  = 2,
    parameter int STAT_WIDTH    = 16
);
    logic                     enable;
    logic                     clear_stats;
    logic [REG_ADD_WIDTH-1:0] dec_rs_add;
    logic [REG_ADD_WIDTH-1:0] dec_rt_add;
    logic                     dec_uses_rs;
    logic                     dec_uses_rt;
    logic                     dec_is_branch;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic [REG_ADD_WIDTH-1:0] ex_rd_add;
    logic                     mem_reg_write;
    logic                     mem_mem_read;
    logic [REG_ADD_WIDTH-1:0] mem_rd_add;
    logic                     wb_reg_write;
    logic [REG_ADD_WIDTH-1:0] wb_rd_add;
    logic [FW_BUS_WIDTH-1:0]  fw_mux_rs_select;
    logic [FW_BUS_WIDTH-1:0]  fw_mux_rt_select;
    logic                     stall;
    logic                     id_ex_flush;
    logic [STAT_WIDTH-1:0]    stall_cycles_total;

    modport master (
        output enable, clear_stats,
        output dec_rs_add, dec_rt_add, dec_uses_rs, dec_uses_rt, dec_is_branch,
        output ex_reg_write, ex_mem_read, ex_rd_add,
        output mem_reg_write, mem_mem_read, mem_rd_add,
        output wb_reg_write, wb_rd_add,
        input  fw_mux_rs_select, fw_mux_rt_select, stall, id_ex_flush, stall_cycles_total
    );

    modport slave (
        input  enable, clear_stats,
        input  dec_rs_add, dec_rt_add, dec_uses_rs, dec_uses_rt, dec_is_branch,
        input  ex_reg_write, ex_mem_read, ex_rd_add,
        input  mem_reg_write, mem_mem_read, mem_rd_add,
        input  wb_reg_write, wb_rd_add,
        output fw_mux_rs_select, fw_mux_rt_select, stall, id_ex_flush, stall_cycles_total
    );
endinterface

`default_nettype wire

// File: rtl/hazard_forwarding_unit.sv
// ============================================================================
// Module  : hazard_forwarding_unit
// Brief   : EX/MEM/WB operand forwarding, load-use/branch stall FSM and a
//           saturating stall-cycle counter for the 5-stage MIPS pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_forwarding_unit #(
    parameter int REG_ADD_WIDTH     = 5,
    parameter int FW_BUS_WIDTH      = 2,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_forwarding_unit_if.slave hz
);

    localparam logic [FW_BUS_WIDTH-1:0] c_SEL_RF  = FW_BUS_WIDTH'(0);
    localparam logic [FW_BUS_WIDTH-1:0] c_SEL_MEM = FW_BUS_WIDTH'(1);
    localparam logic [FW_BUS_WIDTH-1:0] c_SEL_WB  = FW_BUS_WIDTH'(2);
    localparam logic [FW_BUS_WIDTH-1:0] c_SEL_EX  = FW_BUS_WIDTH'(3);
    localparam logic [3:0]              c_LOAD_N  = 4'(LOAD_STALL_CYCLES);
    localparam logic [STAT_WIDTH-1:0]   c_STAT_MAX = '1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [3:0]            w_need;
    logic                  w_stall;
    logic [STAT_WIDTH-1:0] r_stat;

    // Index 0 handles rs, index 1 handles rt; both share identical rules.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [REG_ADD_WIDTH-1:0] w_src;
        logic                     w_uses;
        logic                     w_nonzero;
        logic [FW_BUS_WIDTH-1:0]  w_sel;
        logic [3:0]               w_need;

        assign w_src     = (gi == 0) ? hz.dec_rs_add  : hz.dec_rt_add;
        assign w_uses    = (gi == 0) ? hz.dec_uses_rs : hz.dec_uses_rt;
        assign w_nonzero = (w_src != '0);

        always_comb begin
            w_sel = c_SEL_RF;
            if (reset || !w_nonzero) begin
                w_sel = c_SEL_RF;
            end else if (hz.ex_reg_write && !hz.ex_mem_read && (hz.ex_rd_add == w_src)) begin
                w_sel = c_SEL_EX;
            end else if (hz.mem_reg_write && (hz.mem_rd_add == w_src)) begin
                w_sel = c_SEL_MEM;
            end else if (hz.wb_reg_write && (hz.wb_rd_add == w_src)) begin
                w_sel = c_SEL_WB;
            end
        end

        // The youngest producer decides; an older MEM load is shadowed by EX.
        always_comb begin
            w_need = 4'd0;
            if (w_uses && w_nonzero) begin
                if (hz.ex_mem_read && (hz.ex_rd_add == w_src)) begin
                    w_need = hz.dec_is_branch ? (c_LOAD_N + 4'd1) : c_LOAD_N;
                end else if (hz.ex_reg_write && (hz.ex_rd_add == w_src)) begin
                    w_need = hz.dec_is_branch ? 4'd1 : 4'd0;
                end else if (hz.mem_mem_read && (hz.mem_rd_add == w_src) && hz.dec_is_branch) begin
                    w_need = c_LOAD_N;
                end
            end
        end
    end

    assign w_need = (g_src[0].w_need > g_src[1].w_need) ? g_src[0].w_need : g_src[1].w_need;

    assign hz.fw_mux_rs_select = g_src[0].w_sel;
    assign hz.fw_mux_rt_select = g_src[1].w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The detecting IDLE cycle is itself the first bubble, so STALL covers N-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = (w_need != 4'd0);
                if (hz.enable && (w_need > 4'd1)) begin
                    w_state_nxt = S_STALL;
                    w_cnt_nxt   = 3'(w_need - 4'd1);
                end
            end
            S_STALL: begin
                w_stall = 1'b1;
                if (hz.enable) begin
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    assign hz.stall       = w_stall;
    assign hz.id_ex_flush = w_stall;

    always_ff @(posedge clk) begin
        if (reset || hz.clear_stats) begin
            r_stat <= '0;
        end else if (hz.enable && w_stall && (r_stat != c_STAT_MAX)) begin
            r_stat <= r_stat + STAT_WIDTH'(1);
        end
    end

    assign hz.stall_cycles_total = r_stat;

endmodule

`default_nettype wire
